// File: rtl/vga_timing_gen.sv
// VGA scan/pixel engine: h/v counters, framebuffer addressing, and sync/DE/RGB
// realigned to a configurable read latency, all advancing on pix_en strobes.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned PIX_LAT  = 1,
   parameter bit          SCALE    = 1'b0
) (
   input  logic        vga_clk,
   input  logic        clrn,
   input  logic        pix_en,
   input  logic [11:0] d_in,
   output logic [9:0]  row_addr,
   output logic [10:0] col_addr,
   output logic        addr_vld,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        rdn,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_BEG   = 11'(H_SYNC + H_BP);
   localparam logic [10:0] V_BEG   = 11'(V_SYNC + V_BP);
   localparam logic [11:0] H_SEND  = 12'(H_SYNC);
   localparam logic [11:0] V_SEND  = 12'(V_SYNC);
   localparam logic [11:0] H_ABEG  = 12'(H_SYNC + H_BP);
   localparam logic [11:0] V_ABEG  = 12'(V_SYNC + V_BP);
   localparam logic [11:0] H_AEND  = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0] V_AEND  = 12'(V_SYNC + V_BP + V_ACTIVE);

   typedef struct packed {
      logic vld;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
   } ctrl_t;

   logic [10:0] h_cnt, v_cnt;
   logic [10:0] col_full, row_full, col_sel, row_sel;
   logic        h_act, v_act;
   ctrl_t       ctrl0;
   ctrl_t [PIX_LAT:0]   dly;
   ctrl_t [PIX_LAT+1:0] chain;
   ctrl_t       out_c;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   always_comb begin
      h_act    = ({1'b0, h_cnt} >= H_ABEG) && ({1'b0, h_cnt} < H_AEND);
      v_act    = ({1'b0, v_cnt} >= V_ABEG) && ({1'b0, v_cnt} < V_AEND);
      col_full = h_cnt - H_BEG;
      row_full = v_cnt - V_BEG;
      col_sel  = SCALE ? (col_full >> 1) : col_full;
      row_sel  = SCALE ? (row_full >> 1) : row_full;
      ctrl0     = '0;
      ctrl0.vld = h_act && v_act;
      ctrl0.hs  = {1'b0, h_cnt} < H_SEND;
      ctrl0.vs  = {1'b0, v_cnt} < V_SEND;
      ctrl0.ls  = (h_cnt == H_BEG) && v_act;
      ctrl0.fs  = (h_cnt == H_BEG) && (v_cnt == V_BEG);
   end

   // chain[1] is the stage-1 control word, chain[PIX_LAT+1] feeds the pins;
   // this keeps PIX_LAT=0 free of empty part-selects.
   always_comb chain = {dly, ctrl0};
   assign out_c    = chain[PIX_LAT+1];
   assign addr_vld = chain[1].vld;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         row_addr <= '0;
         col_addr <= '0;
         dly      <= '0;
      end else if (pix_en) begin
         row_addr <= row_sel[9:0];
         col_addr <= col_sel;
         dly      <= chain[PIX_LAT:0];
      end
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         rdn         <= 1'b1;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else if (pix_en) begin
         r           <= out_c.vld ? d_in[3:0]  : '0;
         g           <= out_c.vld ? d_in[7:4]  : '0;
         b           <= out_c.vld ? d_in[11:8] : '0;
         rdn         <= ~out_c.vld;
         hsync       <= out_c.hs ? HS_POL : ~HS_POL;
         vsync       <= out_c.vs ? VS_POL : ~VS_POL;
         line_start  <= out_c.ls;
         frame_start <= out_c.fs;
         if (out_c.fs) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances checked every cycle
// against a position-arithmetic model driven by a count of pix_en strobes.
module tb_vga_timing_gen;

   localparam int HS = 3, HB = 2, HA = 8, HF = 2;
   localparam int VS = 2, VB = 2, VA = 6, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FT = HT * VT;
   localparam int HAB = HS + HB;
   localparam int VAB = VS + VB;
   localparam int F0 = VAB * HT + HAB;

   typedef struct packed {
      logic        vld;
      logic [9:0]  row;
      logic [10:0] col;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        rdn;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
      logic [7:0]  fc;
   } obs_t;

   logic vga_clk = 1'b0;
   logic clrn    = 1'b0;
   logic pix_en  = 1'b0;
   logic [11:0] d_in_a = '0, d_in_b = '0;

   logic [9:0]  row_addr_a, row_addr_b;
   logic [10:0] col_addr_a, col_addr_b;
   logic        addr_vld_a, addr_vld_b;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic        rdn_a, hsync_a, vsync_a, line_start_a, frame_start_a;
   logic        rdn_b, hsync_b, vsync_b, line_start_b, frame_start_b;
   logic [7:0]  frame_cnt_a, frame_cnt_b;

   int s = 0;
   int n_checks = 0;
   int n_fail = 0;
   int first_rdn_a = -1, first_rdn_b = -1;
   int fs_count_a = 0, hs_act_a = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .SCALE(1'b0)
   ) dut_a (
      .vga_clk(vga_clk), .clrn(clrn), .pix_en(pix_en), .d_in(d_in_a),
      .row_addr(row_addr_a), .col_addr(col_addr_a), .addr_vld(addr_vld_a),
      .r(r_a), .g(g_a), .b(b_a), .rdn(rdn_a), .hsync(hsync_a), .vsync(vsync_a),
      .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b0), .PIX_LAT(0), .SCALE(1'b1)
   ) dut_b (
      .vga_clk(vga_clk), .clrn(clrn), .pix_en(pix_en), .d_in(d_in_b),
      .row_addr(row_addr_b), .col_addr(col_addr_b), .addr_vld(addr_vld_b),
      .r(r_b), .g(g_b), .b(b_b), .rdn(rdn_b), .hsync(hsync_b), .vsync(vsync_b),
      .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
   );

   function automatic bit is_act(int h, int v);
      return h >= HAB && h < HAB + HA && v >= VAB && v < VAB + VA;
   endfunction

   // Pixel content a framebuffer would hold: {row[3:0], col[7:0]} of the fetched address.
   function automatic logic [11:0] pix(int p, bit scale);
      logic [10:0] rw, cl;
      rw = 11'((p / HT) % VT - VAB);
      cl = 11'(p % HT - HAB);
      if (scale) begin
         rw = rw >> 1;
         cl = cl >> 1;
      end
      return {rw[3:0], cl[7:0]};
   endfunction

   function automatic logic [11:0] src(int q, bit scale);
      if (q >= 0 && is_act(q % HT, (q / HT) % VT)) return pix(q, scale);
      return 12'($urandom);
   endfunction

   // Expected outputs after s strobes since reset release: stage 1 shows
   // position s-1, pins show position s-lat-2.
   function automatic obs_t model(int st, int lat, bit scale, bit hpol, bit vpol);
      obs_t e;
      int q, o, h, v;
      logic [10:0] rw, cl;
      logic [11:0] px;
      e = '0;
      e.rdn = 1'b1;
      e.hs  = ~hpol;
      e.vs  = ~vpol;
      if (st >= 1) begin
         q = st - 1;
         h = q % HT;
         v = (q / HT) % VT;
         e.vld = is_act(h, v);
         if (e.vld) begin
            rw = 11'(v - VAB);
            cl = 11'(h - HAB);
            if (scale) begin
               rw = rw >> 1;
               cl = cl >> 1;
            end
            e.row = rw[9:0];
            e.col = cl;
         end
      end
      o = st - lat - 2;
      if (o >= 0) begin
         h = o % HT;
         v = (o / HT) % VT;
         e.hs = (h < HS) ? hpol : ~hpol;
         e.vs = (v < VS) ? vpol : ~vpol;
         if (is_act(h, v)) begin
            px    = pix(o, scale);
            e.rdn = 1'b0;
            e.r   = px[3:0];
            e.g   = px[7:4];
            e.b   = px[11:8];
            e.ls  = (h == HAB);
         end
         e.fs = (h == HAB) && (v == VAB);
         e.fc = 8'((o >= F0) ? (o - F0) / FT + 1 : 0);
      end
      return e;
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t exp);
      n_checks++;
      if (!exp.vld) begin
         got.row = '0; got.col = '0;
      end
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s s=%0d got=%h want=%h (vld,row,col,r,g,b,rdn,hs,vs,ls,fs,fcnt)",
                     name, s, got, exp);
      end
   endtask

   task automatic check_val(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   function automatic obs_t obs_a();
      return {addr_vld_a, row_addr_a, col_addr_a, r_a, g_a, b_a, rdn_a,
              hsync_a, vsync_a, line_start_a, frame_start_a, frame_cnt_a};
   endfunction

   function automatic obs_t obs_b();
      return {addr_vld_b, row_addr_b, col_addr_b, r_b, g_b, b_b, rdn_b,
              hsync_b, vsync_b, line_start_b, frame_start_b, frame_cnt_b};
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_a"}, obs_a(), model(0, 2, 1'b0, 1'b0, 1'b0));
      check({tag, "_b"}, obs_b(), model(0, 0, 1'b1, 1'b1, 1'b0));
      check_val({tag, "_hsync_b_pol1"}, int'(hsync_b), 0);
      check_val({tag, "_rdn_a"}, int'(rdn_a), 1);
      check_val({tag, "_addr_a"}, int'(row_addr_a) + int'(col_addr_a), 0);
   endtask

   task automatic step(input bit en);
      @(negedge vga_clk);
      pix_en = en;
      d_in_a = src(s - 3, 1'b0);
      d_in_b = src(s - 1, 1'b1);
      @(posedge vga_clk);
      if (en) s++;
      #1;
      check("dut_a", obs_a(), model(s, 2, 1'b0, 1'b0, 1'b0));
      check("dut_b", obs_b(), model(s, 0, 1'b1, 1'b1, 1'b0));
      if (en) begin
         if (first_rdn_a < 0 && !rdn_a) first_rdn_a = s;
         if (first_rdn_b < 0 && !rdn_b) first_rdn_b = s;
         if (frame_start_a) fs_count_a++;
         if (s >= 4 && s < 4 + FT && !hsync_a) hs_act_a++;
      end
   endtask

   initial begin
      int guard;
      repeat (3) @(negedge vga_clk);
      #1 check_reset_state("reset");
      @(negedge vga_clk);
      clrn = 1'b1;
      s = 0;

      repeat (257 * FT) step(1'b1);
      check_val("first_rdn_a", first_rdn_a, F0 + 4);
      check_val("first_rdn_b", first_rdn_b, F0 + 2);
      check_val("hsync_active_per_frame_a", hs_act_a, HS * VT);
      check_val("frame_start_count_a", fs_count_a, 257);
      check_val("frame_cnt_wrap_a", int'(frame_cnt_a), 1);
      check_val("frame_cnt_wrap_b", int'(frame_cnt_b), 1);

      repeat (3000) step($urandom_range(0, 3) == 0);

      guard = 0;
      while (!((s % HT) == 9 && ((s / HT) % VT) == 5) && guard < 2 * FT) begin
         step(1'b1);
         guard++;
      end
      check_val("reach_mid_line", int'(guard < 2 * FT), 1);

      @(posedge vga_clk);
      #3 clrn = 1'b0;
      pix_en = 1'b0;
      #1 check_reset_state("mid_reset");
      s = 0;
      repeat (2) @(negedge vga_clk);
      clrn = 1'b1;

      repeat (600) step($urandom_range(0, 1) == 1);
      repeat (400) step(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
